// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes and default parameters for the game controller
//
// Purpose : state encoding and default parameters shared by game_controller
//           and its key_debounce sub-module.
// Contents: P_KEY, ENTER_BIT_DEF, DEBOUNCE_CYCLES_DEF, state_t (S_INIT..S_RESULT).
package game_pkg;

  localparam int P_KEY               = 4;
  localparam int ENTER_BIT_DEF       = 1;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz

  // Codes are exposed on state_dbg, so the encoding is fixed, not left to the tool.
  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SETUP      = 3'd1,
    S_PLAY_FPGA  = 3'd2,
    S_PLAY_USER  = 3'd3,
    S_CHECK      = 3'd4,
    S_NEXT_ROUND = 3'd5,
    S_ADVANCE    = 3'd6,
    S_RESULT     = 3'd7
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - ENTER button synchronizer, debouncer and press pulse
//
// Purpose: brings an asynchronous active-low button into the clock_50 domain,
//          accepts a new level only after DEBOUNCE_CYCLES consecutive equal
//          samples, and emits a one-cycle pulse on each accepted press (1->0).
// Ports  : clock_50 (in)  system clock
//          R        (in)  synchronous active-high reset, clears everything
//          key_n    (in)  raw button, active-low, asynchronous
//          press_p  (out) one-cycle pulse per debounced press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clock_50,
  input  logic R,
  input  logic key_n,
  output logic press_p
);

  localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   C_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with r_stable;
  // any agreeing sample restarts the count, so only a clean run is accepted.
  always_ff @(posedge clock_50) begin
    if (R) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync0 <= key_n;
      r_sync1 <= r_sync0;
      r_press <= 1'b0;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= C_LAST) begin
        // this is the DEBOUNCE_CYCLES-th disagreeing sample: accept the level
        r_stable <= r_sync1;
        r_cnt    <= '0;
        r_press  <= r_stable & ~r_sync1;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press_p = r_press;

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - Moore FSM sequencing the game datapath
//
// Purpose: drives datapath commands (r1, r2, e1..e4, sel) from the current state,
//          advances on datapath status flags and the debounced ENTER press.
// Ports  : clock_50 (in)  system clock        R (in) sync active-high reset
//          key[P_KEY] (in) raw buttons, active-low; key[ENTER_BIT] is ENTER
//          end_fpga, end_user, end_time, win, match (in) datapath status
//          r1, r2, e1, e2, e3, e4, sel (out) datapath commands
//          state_dbg[3] (out) current state code
module game_controller #(
  parameter int P_KEY           = game_pkg::P_KEY,
  parameter int ENTER_BIT       = game_pkg::ENTER_BIT_DEF,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic             clock_50,
  input  logic             R,
  input  logic [P_KEY-1:0] key,
  input  logic             end_fpga,
  input  logic             end_user,
  input  logic             end_time,
  input  logic             win,
  input  logic             match,
  output logic             r1,
  output logic             r2,
  output logic             e1,
  output logic             e2,
  output logic             e3,
  output logic             e4,
  output logic             sel,
  output logic [2:0]       state_dbg
);

  import game_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   w_enter_p;
  logic   w_unused_keys;

  // Only ENTER is used; the other buttons belong to the datapath side.
  assign w_unused_keys = &key;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock_50 (clock_50),
    .R        (R),
    .key_n    (key[ENTER_BIT]),
    .press_p  (w_enter_p)
  );

  always_ff @(posedge clock_50) begin
    if (R) r_state <= S_INIT;
    else   r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:       w_next = S_SETUP;
      S_SETUP:      if (w_enter_p) w_next = S_PLAY_FPGA;
      S_PLAY_FPGA:  if (end_fpga)  w_next = S_PLAY_USER;
      S_PLAY_USER: begin
        // a timeout wins over a simultaneous end of user entry
        if (end_time)      w_next = S_RESULT;
        else if (end_user) w_next = S_CHECK;
      end
      S_CHECK:      w_next = match ? S_NEXT_ROUND : S_RESULT;
      S_NEXT_ROUND: w_next = S_ADVANCE;
      // win is checked one cycle after the e4 increment so the count has settled
      S_ADVANCE:    w_next = win ? S_RESULT : S_PLAY_FPGA;
      S_RESULT:     if (w_enter_p) w_next = S_INIT;
      default:      w_next = S_INIT;
    endcase
  end

  always_comb begin
    r1  = 1'b0;
    r2  = 1'b0;
    e1  = 1'b0;
    e2  = 1'b0;
    e3  = 1'b0;
    e4  = 1'b0;
    sel = 1'b1;
    case (r_state)
      S_INIT:       begin r1 = 1'b1; r2 = 1'b1; end
      S_SETUP:      e1 = 1'b1;
      S_PLAY_FPGA:  e3 = 1'b1;
      S_PLAY_USER:  e2 = 1'b1;
      S_NEXT_ROUND: begin e4 = 1'b1; r2 = 1'b1; end
      S_RESULT:     sel = 1'b0;
      default:      sel = 1'b1;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - scoreboard bench for game_controller
module tb_game_controller;

  logic       clock_50;
  logic       R;
  logic [3:0] key;
  logic       end_fpga, end_user, end_time, win, match;
  logic       r1, r2, e1, e2, e3, e4, sel;
  logic [2:0] state_dbg;
  logic [6:0] w_outs;

  game_controller #(
    .P_KEY(4),
    .ENTER_BIT(1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock_50  (clock_50),
    .R         (R),
    .key       (key),
    .end_fpga  (end_fpga),
    .end_user  (end_user),
    .end_time  (end_time),
    .win       (win),
    .match     (match),
    .r1        (r1),
    .r2        (r2),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .e4        (e4),
    .sel       (sel),
    .state_dbg (state_dbg)
  );

  assign w_outs = {r1, r2, e1, e2, e3, e4, sel};

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [6:0] outs;
    string      tag;
  } exp_t;

  exp_t  q[$];
  exp_t  m_e;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  always @(posedge clock_50) cyc <= cyc + 1;

  // Expected {r1,r2,e1,e2,e3,e4,sel} per state, written out by hand.
  function automatic logic [6:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b1100001;
      3'd1:    return 7'b0010001;
      3'd2:    return 7'b0000101;
      3'd3:    return 7'b0001001;
      3'd4:    return 7'b0000001;
      3'd5:    return 7'b0100011;
      3'd6:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Monitor: each negedge, retire every expectation due this cycle.
  always @(negedge clock_50) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.cyc != cyc || state_dbg !== m_e.st || w_outs !== m_e.outs) begin
        n_errors++;
        $display("FAIL %s cyc=%0d: got state=%0d outs=%b, expected state=%0d outs=%b (due cyc %0d)",
                 m_e.tag, cyc, state_dbg, w_outs, m_e.st, m_e.outs, m_e.cyc);
      end
    end
  end

  task automatic step_expect(input logic [2:0] s);
    exp_t e;
    @(posedge clock_50);
    #1;
    e.cyc  = cyc;
    e.st   = s;
    e.outs = exp_outs(s);
    e.tag  = phase;
    q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [2:0] s);
    for (int i = 0; i < n; i++) step_expect(s);
  endtask

  // Press ENTER long enough to debounce (2 sync + 4 samples + pulse register),
  // keep it down a while, then release and wait past a full debounce window.
  task automatic press_enter(input logic [2:0] s_before, input logic [2:0] s_after);
    logic [2:0] fin;
    key[1] = 1'b0;
    hold(6, s_before);
    step_expect(s_after);
    fin = s_after;
    if (s_after == 3'd0) begin
      step_expect(3'd1);
      fin = 3'd1;
    end
    hold(3, fin);
    key[1] = 1'b1;
    hold(8, fin);
  endtask

  initial begin
    R = 1'b1; key = 4'hF;
    end_fpga = 0; end_user = 0; end_time = 0; win = 0; match = 0;

    phase = "reset";
    hold(2, 3'd0);
    R = 1'b0;
    phase = "reset_release";
    hold(2, 3'd1);

    phase = "short_glitch";
    key[1] = 1'b0;
    hold(3, 3'd1);
    key[1] = 1'b1;
    hold(8, 3'd1);

    phase = "enter_setup";
    press_enter(3'd1, 3'd2);

    phase = "good_round";
    end_fpga = 1;
    step_expect(3'd3);
    end_fpga = 0;
    end_user = 1; match = 1; win = 0;
    step_expect(3'd4);
    step_expect(3'd5);
    step_expect(3'd6);
    step_expect(3'd2);
    end_user = 0; match = 0;
    hold(2, 3'd2);

    phase = "timeout_priority";
    end_fpga = 1;
    step_expect(3'd3);
    end_fpga = 0;
    end_user = 1; end_time = 1;
    step_expect(3'd7);
    end_user = 0; end_time = 0;
    hold(2, 3'd7);

    phase = "result_enter";
    press_enter(3'd7, 3'd0);

    phase = "loss";
    press_enter(3'd1, 3'd2);
    end_fpga = 1;
    step_expect(3'd3);
    end_fpga = 0;
    end_user = 1; match = 0;
    step_expect(3'd4);
    step_expect(3'd7);
    end_user = 0;
    press_enter(3'd7, 3'd0);

    phase = "win";
    press_enter(3'd1, 3'd2);
    end_fpga = 1;
    step_expect(3'd3);
    end_fpga = 0;
    end_user = 1; match = 1; win = 1;
    step_expect(3'd4);
    step_expect(3'd5);
    step_expect(3'd6);
    step_expect(3'd7);
    end_user = 0; match = 0; win = 0;
    press_enter(3'd7, 3'd0);

    phase = "midgame_reset";
    press_enter(3'd1, 3'd2);
    end_fpga = 1;
    step_expect(3'd3);
    end_fpga = 0;
    hold(2, 3'd3);
    R = 1'b1;
    step_expect(3'd0);
    R = 1'b0;
    step_expect(3'd1);

    phase = "enter_ignored_play";
    press_enter(3'd1, 3'd2);
    press_enter(3'd2, 3'd2);

    repeat (2) @(posedge clock_50);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
